// File: rtl/spart_receiver.sv
// SPART receive stage: synchronises RxD, oversamples 8N1 frames on the baud enable tick
// and holds the last good byte with data-available, overrun and framing-error status.
module spart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RxD,
    input  logic                 enable,
    input  logic                 rd_clr,
    output logic [DATA_BITS-1:0] rec_buff,
    output logic                 rec_data_avail,
    output logic                 overrun,
    output logic                 framing_err,
    output logic [2:0]           state_dbg
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               state, state_nx;
    logic [TW-1:0]        tick_cnt, tick_nx;
    logic [BW-1:0]        bit_cnt, bit_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 rx_meta, rx_s;
    logic                 done, ferr;

    assign state_dbg = state;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nx;
            tick_cnt <= tick_nx;
            bit_cnt  <= bit_nx;
            shreg    <= shreg_nx;
        end
    end

    // Every transition happens on an enable tick; tick_cnt holds the sample point mid-bit.
    always_comb begin
        state_nx = state;
        tick_nx  = tick_cnt;
        bit_nx   = bit_cnt;
        shreg_nx = shreg;
        done     = 1'b0;
        ferr     = 1'b0;
        if (enable) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_nx = S_START;
                        tick_nx  = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt == HALF_TICK) begin
                        tick_nx = '0;
                        bit_nx  = '0;
                        state_nx = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_nx = tick_cnt + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_nx = '0;
                        shreg_nx = shreg >> 1;
                        shreg_nx[DATA_BITS-1] = rx_s;
                        if (bit_cnt == LAST_BIT) begin
                            state_nx = S_STOP;
                        end else begin
                            bit_nx = bit_cnt + BW'(1);
                        end
                    end else begin
                        tick_nx = tick_cnt + TW'(1);
                    end
                end
                S_STOP: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_nx = '0;
                        if (rx_s) begin
                            done     = 1'b1;
                            state_nx = S_IDLE;
                        end else begin
                            ferr     = 1'b1;
                            state_nx = S_BREAK;
                        end
                    end else begin
                        tick_nx = tick_cnt + TW'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state_nx = S_IDLE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // A completing frame beats a simultaneous read: the new byte stays unread.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_buff       <= '0;
            rec_data_avail <= 1'b0;
            overrun        <= 1'b0;
            framing_err    <= 1'b0;
        end else begin
            framing_err <= ferr;
            if (done) begin
                rec_buff       <= shreg;
                rec_data_avail <= 1'b1;
                overrun        <= rd_clr ? 1'b0 : (overrun | rec_data_avail);
            end else if (rd_clr) begin
                rec_data_avail <= 1'b0;
                overrun        <= 1'b0;
            end
        end
    end

endmodule
